// File: rtl/intra_pkg.sv
// Shared definitions for the chroma intra prediction / mode decision blocks:
// pixel width, H.264 chroma mode codes and the mode-decision FSM states.
package intra_pkg;

    localparam int unsigned PIX_W = 8;

    localparam logic [1:0] MODE_DC = 2'd0;
    localparam logic [1:0] MODE_H  = 2'd1;
    localparam logic [1:0] MODE_V  = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DECIDE
    } state_e;

endpackage

// File: rtl/sad_row8.sv
// Combinational sum of absolute differences over eight pixel pairs (one block row).
module sad_row8 #(
    parameter int unsigned PIX_W = intra_pkg::PIX_W
) (
    input  logic [7:0][PIX_W-1:0] a,
    input  logic [7:0][PIX_W-1:0] b,
    output logic [10:0]           sum
);

    logic [PIX_W-1:0] diff;

    always_comb begin
        sum  = '0;
        diff = '0;
        for (int i = 0; i < 8; i++) begin
            diff = (a[i] > b[i]) ? (a[i] - b[i]) : (b[i] - a[i]);
            sum  = sum + 11'(diff);
        end
    end

endmodule

// File: rtl/modesel_chroma8x8.sv
// Chroma 8x8 intra mode decision: row-serial SAD of DC/H/V planes against the original block.
// Optional macro MODESEL_SAD_ALL_EN exposes the three per-mode SADs as extra outputs.
module modesel_chroma8x8 #(
    parameter int unsigned PIX_W = intra_pkg::PIX_W,
    parameter int unsigned SAD_W = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [63:0][PIX_W-1:0]  origpixels,
    input  logic [63:0][PIX_W-1:0]  vpred,
    input  logic [63:0][PIX_W-1:0]  hpred,
    input  logic [63:0][PIX_W-1:0]  dcpred,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              best_mode,
    output logic [SAD_W-1:0]        best_sad
`ifdef MODESEL_SAD_ALL_EN
    ,
    output logic [SAD_W-1:0]        sad_dc,
    output logic [SAD_W-1:0]        sad_h,
    output logic [SAD_W-1:0]        sad_v
`endif
);

    import intra_pkg::*;

    state_e           state_q, state_d;
    logic [2:0]       row_q;
    logic [SAD_W-1:0] acc_dc_q, acc_h_q, acc_v_q;
    logic [SAD_W-1:0] sum_dc, sum_h, sum_v;
    logic [SAD_W-1:0] dec_sad;
    logic [1:0]       dec_mode;
    logic             last_row;

    logic [7:0][PIX_W-1:0] orig_row, v_row, h_row, dc_row;
    logic [10:0]           row_dc, row_h, row_v;

    assign orig_row = origpixels[{row_q, 3'b000} +: 8];
    assign v_row    = vpred[{row_q, 3'b000} +: 8];
    assign h_row    = hpred[{row_q, 3'b000} +: 8];
    assign dc_row   = dcpred[{row_q, 3'b000} +: 8];

    sad_row8 #(.PIX_W(PIX_W)) u_sad_dc (.a(orig_row), .b(dc_row), .sum(row_dc));
    sad_row8 #(.PIX_W(PIX_W)) u_sad_h  (.a(orig_row), .b(h_row),  .sum(row_h));
    sad_row8 #(.PIX_W(PIX_W)) u_sad_v  (.a(orig_row), .b(v_row),  .sum(row_v));

    assign sum_dc   = acc_dc_q + SAD_W'(row_dc);
    assign sum_h    = acc_h_q  + SAD_W'(row_h);
    assign sum_v    = acc_v_q  + SAD_W'(row_v);
    assign last_row = (state_q == ACCUM) && (row_q == 3'd7);

    // Strict less-than in DC, H, V order so ties keep the lowest mode code.
    always_comb begin
        dec_mode = MODE_DC;
        dec_sad  = sum_dc;
        if (sum_h < dec_sad) begin
            dec_mode = MODE_H;
            dec_sad  = sum_h;
        end
        if (sum_v < dec_sad) begin
            dec_mode = MODE_V;
            dec_sad  = sum_v;
        end
    end

    // The decision is taken on the final row sums so the result registers are
    // already valid during the DECIDE cycle, together with done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            row_q     <= '0;
            acc_dc_q  <= '0;
            acc_h_q   <= '0;
            acc_v_q   <= '0;
            best_mode <= MODE_DC;
            best_sad  <= '0;
`ifdef MODESEL_SAD_ALL_EN
            sad_dc    <= '0;
            sad_h     <= '0;
            sad_v     <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                row_q    <= '0;
                acc_dc_q <= '0;
                acc_h_q  <= '0;
                acc_v_q  <= '0;
            end else if (state_q == ACCUM) begin
                row_q    <= row_q + 3'd1;
                acc_dc_q <= sum_dc;
                acc_h_q  <= sum_h;
                acc_v_q  <= sum_v;
            end
            if (last_row) begin
                best_mode <= dec_mode;
                best_sad  <= dec_sad;
`ifdef MODESEL_SAD_ALL_EN
                sad_dc    <= sum_dc;
                sad_h     <= sum_h;
                sad_v     <= sum_v;
`endif
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (row_q == 3'd7) state_d = DECIDE;
            DECIDE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DECIDE);
    end

endmodule

// File: doc/modesel_chroma8x8.md
Name: modesel_chroma8x8

Overview:
- Chroma 8x8 intra mode decision block. It is the consumer of the vertical, horizontal and DC prediction planes produced by the chroma 8x8 predictor.
- Compares each prediction plane against the original 8x8 block using sum of absolute differences (SAD), one row per cycle.
- Reports the best mode code and its SAD to the encoder control FSM.

Parameters:
- PIX_W, 8, pixel bit width.
- SAD_W, 14, SAD accumulator width; covers 64*255 = 16320 without overflow.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a decision; accepted only in IDLE.
- origpixels  input  [PIX_W-1:0] x64  original block, raster order (index = col + 8*row).
- vpred  input  [PIX_W-1:0] x64  vertical prediction plane, same ordering.
- hpred  input  [PIX_W-1:0] x64  horizontal prediction plane.
- dcpred  input  [PIX_W-1:0] x64  DC prediction plane.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; best_mode and best_sad are valid from this cycle.
- best_mode  output  2  H.264 chroma mode code: 0 = DC, 1 = horizontal, 2 = vertical.
- best_sad  output  SAD_W  SAD of the chosen mode.

Behaviour:
- Reset: state IDLE, row counter 0, all three accumulators 0, busy 0, done 0, best_mode 0, best_sad 0.
- Input stability: origpixels and all pred planes must be held stable from the start cycle through the done cycle. The block does not latch the planes.
- FSM states:
  - IDLE: start=1 moves to ACCUM, clears the accumulators and sets row = 0.
  - ACCUM: each cycle, for each mode, add the sum over the 8 columns of |orig - pred| for the current row, all 3 modes in parallel. Increment row. After row 7, move to DECIDE.
  - DECIDE: compare the three SADs, register best_mode/best_sad, pulse done, return to IDLE.
- Latency:
  - start sampled in cycle T.
  - Rows 0..7 are accumulated in cycles T+1..T+8.
  - done=1 in cycle T+9.
  - busy=1 in cycles T+1..T+9.
- Arithmetic:
  - Absolute difference is computed unsigned: larger operand minus smaller operand.
  - Per-row sum uses 11 bits; accumulators use SAD_W bits; no saturation is needed.
- Tie-break: the lowest mode code wins (DC before H before V), using strict less-than comparisons in the order DC, H, V.
- Output hold: best_mode/best_sad hold their value after done until the next DECIDE or reset. done is 0 outside the DECIDE cycle.
- start while busy: ignored, with no effect on the current decision.
- start in the same cycle as done: ignored, because the FSM is in DECIDE. The caller must re-assert start in the next cycle.
- reset mid-operation: aborts the decision. No done pulse is produced, and the reset values apply on the next edge.

Optional Feature:
- Macro: MODESEL_SAD_ALL_EN.
- When defined: adds outputs sad_dc, sad_h, sad_v (SAD_W each). They are registered in the DECIDE cycle, valid with done, hold like best_sad, and reset to 0. They are used for rate-distortion tuning and debug.
- When undefined: these ports and registers do not exist. The core behaviour is identical.

Decomposition:
- Shared package intra_pkg holds:
  - PIX_W.
  - Mode code constants MODE_DC=2'd0, MODE_H=2'd1, MODE_V=2'd2.
  - The FSM state enum (IDLE, ACCUM, DECIDE).
- One sub-module, sad_row8: combinational SAD of eight pixel pairs producing an 11-bit sum. It is instantiated three times, once per mode. Row selection muxes stay in the top level.

Test Plan:
- Vertical wins:
  - Stimulus: orig all 100, vpred all 100, hpred all 50, dcpred all 75; pulse start.
  - Response: done at T+9, best_mode=2, best_sad=0. With MODESEL_SAD_ALL_EN: sad_h=3200, sad_dc=1600.
- Horizontal wins:
  - Stimulus: orig row r = 10*r, hpred row r = 10*r, vpred all 0, dcpred all 35.
  - Response: best_mode=1, best_sad=0. With the feature: sad_v=2240.
- Three-way tie:
  - Stimulus: orig all 0, all preds 0.
  - Response: best_mode=0, best_sad=0 (DC wins the tie).
- Max SAD, no overflow:
  - Stimulus: orig all 255, all preds 0.
  - Response: best_mode=0, best_sad=16320.
- Protocol:
  - start re-pulsed during ACCUM -> exactly one done pulse at T+9; busy low at T+10.
  - Reset asserted at T+4 -> no done pulse; all outputs 0; a fresh start afterwards completes normally.
